posit_to_float: RTL and testbench
=================================

# posit_to_float

Pipelined converter from an N-bit posit (es exponent bits) to an IEEE-754 single-precision word. It is the decode-direction counterpart of the posit arithmetic units: results of posit add/multiply chains are handed to host-visible float32 buffers. Parameters are restricted so that the conversion is always exact, so no rounding logic is needed. Fixed latency of 3 cycles, with a `start`/`done` strobe that flows alongside the data.

## Interface
Parameters:
- `N`, 8: posit width. Legal range 3..25.
- `es`, 4: posit exponent field width. Legal only if (N-1)·2^es ≤ 126. Elaboration fails otherwise.
- `Bs`, log2(N): width of the regime-count and shift fields (derived).

Ports:
- `aclk`  in  1  clock. All logic is clocked on the rising edge.
- `aresetn`  in  1  reset, asynchronous and active-low.
- `in`  in  N  posit operand, two's-complement encoded.
- `start`  in  1  `in` is valid this cycle. Any cycle may carry a new operand (throughput 1/cycle).
- `result`  out  32  IEEE-754 single-precision value.
- `inf`  out  1  operand was NaR (1 followed by zeros).
- `zero`  out  1  operand was all zeros.
- `done`  out  1  `result`, `inf` and `zero` are valid this cycle.

## Operation
- Stage 1 (register `in`, `start`):
  - s = in[N-1]; nz = |in[N-2:0].
  - NaR = s & ~nz; zero = ~s & ~nz.
  - x = s ? -in : in (N-bit two's complement).
- Stage 2 (regime decode):
  - rc = x[N-2]; L = count of leading bits of x[N-2:0] equal to rc, saturating at N-1.
  - k = rc ? L-1 : -L (signed, Bs+1 bits).
  - Left-shift x[N-2:0] by L+1 (bits shifted in are 0). This yields the remaining field r.
- Stage 3 (field extraction and packing):
  - e = the top es bits of r. Exponent bits lost off the end are 0 in the low positions (standard posit truncation).
  - frac = the remaining N-3-es bits of r, or fewer; missing low bits are 0.
  - scale = k·2^es + e; float exponent = scale + 127. Always in 1..254 by the parameter constraint.
  - result = {s, exp[7:0], frac left-aligned in 23 bits, zero-padded}. Exact by construction, since fraction bits ≤ 22.
- Specials override stage 3:
  - NaR → result 32'h7FC00000, inf=1, zero=0.
  - zero → result 32'h00000000, zero=1, inf=0.
  - Otherwise inf=zero=0.
- Data registers advance every cycle regardless of `start`. When `done`=0, `result`, `inf` and `zero` are don't-care, but they are driven deterministically from the pipeline.
- The block never stalls. There is no backpressure, so the consumer must accept one result per `done`.

## Timing
- Latency 3: operand sampled at edge T with `start`=1 → `done`=1 with matching `result` at edges T+3 through T+4.
  - Registered pipeline: in → r1 → r2 → r3 = outputs.
- Back-to-back `start` on consecutive cycles produces `done` on consecutive cycles, in order, with no bubbles.
- `done` is `start` delayed exactly 3 cycles. Gaps in `start` are reproduced in `done`.
- Reset, asserted at any time (asynchronous):
  - All pipeline valid bits clear immediately, so `done`=0.
  - `result`=0, `inf`=0, `zero`=0.
  - Operations in flight are discarded. No `done` is produced for any operand sampled before reset.
- Release of reset is synchronized externally. The first operand accepted is the first `start`=1 at a rising edge with `aresetn`=1.
- A `start` on the same edge as `aresetn` rising is accepted.
- Combinational paths: none from inputs to outputs.

## Test plan
(All scenarios use N=8, es=4.)
- Unity and fraction: `in`=8'h40 → `result`=32'h3F800000. `in`=8'h41 → 32'h3FC00000 (1.5). Check `done` exactly 3 cycles after `start`; inf=zero=0.
- Exponent field and negation: `in`=8'h50 → 32'h43800000 (256.0). `in`=8'hC0 → 32'hBF800000 (-1.0).
- Range extremes:
  - maxpos 8'h7F → 32'h6F800000 (2^96); minpos 8'h01 → 32'h0F800000 (2^-96).
  - 8'h81 → 32'hEF800000 (-2^96).
- Specials: 8'h80 → 32'h7FC00000 with inf=1, zero=0. 8'h00 → 32'h00000000 with zero=1, inf=0.
- Streaming: 256 consecutive `start` cycles sweeping all 8-bit codes → 256 consecutive `done` in order, each matching a reference model. Then insert a 2-cycle `start` gap → identical 2-cycle `done` gap.
- Reset mid-flight: issue `start` on 3 consecutive cycles, then pulse `aresetn` low for 1 cycle between clock edges.
  - `done`, `result`, `inf` and `zero` go to 0 asynchronously.
  - No `done` appears afterwards until a new `start`.
  - A new `start` then completes normally after 3 cycles.

Source files
------------

// File: rtl/posit_to_float_if.sv
// posit_to_float_if -- operand/result bundle for the posit-to-float32 converter.
//
// Ports (signals carried by the interface):
//    in      posit operand, N bits, two's-complement encoded
//    start   operand on `in` is valid this cycle
//    result  IEEE-754 single-precision value
//    inf     operand was NaR
//    zero    operand was all zeros
//    done    result/inf/zero are valid this cycle
//
// The master drives operands and consumes results; the slave is the converter.
interface posit_to_float_if #(
   parameter int N = 8
);
   logic [N-1:0] in;
   logic         start;
   logic [31:0]  result;
   logic         inf;
   logic         zero;
   logic         done;

   modport master (
      output in, start,
      input  result, inf, zero, done
   );

   modport slave (
      input  in, start,
      output result, inf, zero, done
   );
endinterface

// File: rtl/posit_to_float.sv
// posit_to_float -- three-stage pipelined conversion of an N-bit posit with
// es exponent bits into an IEEE-754 single-precision word. Parameters are
// restricted so the conversion is always exact, so there is no rounding.
//
// Ports:
//    aclk     clock, rising edge
//    aresetn  asynchronous active-low reset
//    bus      posit_to_float_if slave: in/start in, result/inf/zero/done out
//
// Pipeline: stage 1 takes magnitude and specials, stage 2 decodes the regime,
// stage 3 extracts exponent/fraction and packs the float. done is start
// delayed by exactly three cycles; there is no backpressure.
module posit_to_float #(
   parameter int N  = 8,
   parameter int es = 4,
   parameter int Bs = $clog2(N)
) (
   input logic             aclk,
   input logic             aresetn,
   posit_to_float_if.slave bus
);

   // Bits of the post-regime field that can reach exponent or fraction.
   localparam int TOPW = es + 23;
   localparam int TAKE = (N - 1 < TOPW) ? N - 1 : TOPW;

   // Refuse configurations whose scale range cannot be represented exactly.
   if (N < 3 || N > 25 || es < 0 || (N - 1) * (2 ** es) > 126) begin : g_param_check
      $error("posit_to_float: illegal N/es combination");
   end

   logic             in_nz;
   logic [N-2:0]     in_mag;

   logic             v1;
   logic             s1_sign;
   logic             s1_nar;
   logic             s1_zero;
   logic [N-2:0]     s1_x;

   logic             rc;
   logic             run;
   logic [Bs-1:0]    lead;
   logic signed [Bs:0] lead_s;
   logic signed [Bs:0] k_val;
   logic [Bs:0]      shift_amt;
   logic [N-2:0]     r_field;

   logic             v2;
   logic             s2_sign;
   logic             s2_nar;
   logic             s2_zero;
   logic signed [Bs:0] s2_k;
   logic [N-2:0]     s2_r;

   logic [TOPW-1:0]  top;
   logic signed [Bs+TOPW:0] k_top;
   logic [7:0]       exp_field;
   logic [31:0]      packed_val;

   // Stage 1 inputs: negating only the low N-1 bits is enough, because the
   // low bits of a two's-complement negation depend only on the low bits.
   always_comb begin
      in_nz  = |bus.in[N-2:0];
      in_mag = bus.in[N-1] ? -bus.in[N-2:0] : bus.in[N-2:0];
   end

   // Stage 1 register: sign, special-case flags and magnitude bits.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         v1      <= 1'b0;
         s1_sign <= 1'b0;
         s1_nar  <= 1'b0;
         s1_zero <= 1'b0;
         s1_x    <= '0;
      end else begin
         v1      <= bus.start;
         s1_sign <= bus.in[N-1];
         s1_nar  <= bus.in[N-1] & ~in_nz;
         s1_zero <= ~bus.in[N-1] & ~in_nz;
         s1_x    <= in_mag;
      end
   end

   // Regime decode: count the run of bits equal to the first one (this
   // naturally saturates at N-1), turn it into k, and shift the run plus its
   // terminating bit out. The shift amount is one bit wider than the count so
   // that a run of N-1 followed by +1 does not wrap.
   always_comb begin
      rc   = s1_x[N-2];
      run  = 1'b1;
      lead = '0;
      for (int i = N - 2; i >= 0; i--) begin
         if (run && (s1_x[i] == rc)) begin
            lead = lead + Bs'(1);
         end else begin
            run = 1'b0;
         end
      end
      lead_s    = $signed({1'b0, lead});
      k_val     = rc ? (lead_s - $signed((Bs + 1)'(1))) : -lead_s;
      shift_amt = {1'b0, lead} + (Bs + 1)'(1);
      r_field   = s1_x << shift_amt;
   end

   // Stage 2 register: regime value and the remaining exponent/fraction bits.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         v2      <= 1'b0;
         s2_sign <= 1'b0;
         s2_nar  <= 1'b0;
         s2_zero <= 1'b0;
         s2_k    <= '0;
         s2_r    <= '0;
      end else begin
         v2      <= v1;
         s2_sign <= s1_sign;
         s2_nar  <= s1_nar;
         s2_zero <= s1_zero;
         s2_k    <= k_val;
         s2_r    <= r_field;
      end
   end

   // Field extraction: the remaining bits are left-aligned in a window of
   // es exponent bits followed by 23 fraction bits, so truncated exponent
   // bits and missing fraction bits both read as zero. Because 0 <= e < 2^es,
   // k*2^es + e is simply {k, e}; arithmetic-shifting {k, e, frac} right by
   // 23 gives the signed scale, and only its low 8 bits matter after the bias.
   always_comb begin
      top = '0;
      for (int i = 0; i < TAKE; i++) begin
         top[TOPW-1-i] = s2_r[N-2-i];
      end
      k_top     = {s2_k, top};
      exp_field = 8'(k_top >>> 23) + 8'd127;
      if (s2_nar) begin
         packed_val = 32'h7FC0_0000;
      end else if (s2_zero) begin
         packed_val = 32'h0000_0000;
      end else begin
         packed_val = {s2_sign, exp_field, top[22:0]};
      end
   end

   // Stage 3 register: the outputs themselves, so nothing combinational
   // reaches the ports.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bus.done   <= 1'b0;
         bus.result <= 32'h0000_0000;
         bus.inf    <= 1'b0;
         bus.zero   <= 1'b0;
      end else begin
         bus.done   <= v2;
         bus.result <= packed_val;
         bus.inf    <= s2_nar;
         bus.zero   <= s2_zero;
      end
   end

endmodule

// File: tb/tb_posit_to_float.sv
// tb_posit_to_float -- self-checking bench for posit_to_float (N=8, es=4).
// Expected results are pushed to a scoreboard queue when an operand is driven
// and popped when done is observed; each cycle also checks whether done is
// expected at that point, so latency, ordering and gaps are all covered.
module tb_posit_to_float;

   typedef struct {
      logic [31:0] res;
      logic        inf;
      logic        zero;
      int          cyc;
   } sb_t;

   logic aclk;
   logic aresetn;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   sb_t  sb[$];

   posit_to_float_if #(.N(8)) dut_if ();

   posit_to_float #(.N(8), .es(4)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (dut_if.slave)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Count rising edges so latency can be measured at the falling edge.
   always @(posedge aclk) begin
      cyc <= cyc + 1;
   end

   // Hard stop in case something hangs.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model straight from the posit definition for N=8, es=4.
   function automatic sb_t ref_model(input logic [7:0] p);
      sb_t        r;
      logic [7:0] mag;
      logic       rc;
      int         run;
      int         k;
      int         pos;
      int         e;
      int         fr;
      logic       b;
      r.cyc  = 0;
      r.inf  = 1'b0;
      r.zero = 1'b0;
      r.res  = 32'h0;
      if (p == 8'h00) begin
         r.zero = 1'b1;
         return r;
      end
      if (p == 8'h80) begin
         r.res = 32'h7FC0_0000;
         r.inf = 1'b1;
         return r;
      end
      mag = p[7] ? (~p + 8'd1) : p;
      rc  = mag[6];
      run = 0;
      while (run < 7 && mag[6 - run] == rc) run++;
      k   = rc ? run - 1 : -run;
      pos = 5 - run;
      e   = 0;
      fr  = 0;
      for (int i = 0; i < 5; i++) begin
         b = (pos - i >= 0) ? mag[pos - i] : 1'b0;
         if (i < 4) e = e * 2 + int'(b);
         else fr = int'(b);
      end
      r.res = {p[7], 8'(k * 16 + e + 127), fr[0], 22'b0};
      return r;
   endfunction

   task automatic test_reset();
      aresetn       = 1'b0;
      dut_if.in     = 8'h40;
      dut_if.start  = 1'b1;
      #22;
      checks++;
      if (dut_if.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_done: done=%b, required 0", dut_if.done);
      end
      checks++;
      if (dut_if.result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_result: result=%h, required 00000000", dut_if.result);
      end
      checks++;
      if (dut_if.inf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_inf: inf=%b, required 0", dut_if.inf);
      end
      checks++;
      if (dut_if.zero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_zero: zero=%b, required 0", dut_if.zero);
      end
      @(negedge aclk);
      dut_if.start = 1'b0;
      dut_if.in    = 8'h00;
      aresetn      = 1'b1;
   endtask

   task automatic test_directed();
      logic [7:0]  codes [9];
      logic [31:0] exps  [9];
      logic [8:0]  infs;
      logic [8:0]  zeros;
      sb_t         e;
      sb_t         got;
      logic        exp_done;
      codes = '{8'h40, 8'h41, 8'h50, 8'hC0, 8'h7F, 8'h01, 8'h81, 8'h80, 8'h00};
      exps  = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4380_0000, 32'hBF80_0000,
                32'h6F80_0000, 32'h0F80_0000, 32'hEF80_0000, 32'h7FC0_0000,
                32'h0000_0000};
      infs  = 9'b010000000;
      zeros = 9'b100000000;
      for (int c = 0; c < 9 + 6; c++) begin
         @(negedge aclk);
         exp_done = (sb.size() != 0) && (cyc - sb[0].cyc >= 3);
         checks++;
         if (dut_if.done !== exp_done) begin
            errors++;
            $display("[TB] FAIL directed_done: done=%b at cycle %0d, required %b", dut_if.done, cyc, exp_done);
         end
         if (exp_done) begin
            got = sb.pop_front();
            if (dut_if.done === 1'b1) begin
               checks++;
               if (dut_if.result !== got.res || dut_if.inf !== got.inf || dut_if.zero !== got.zero) begin
                  errors++;
                  $display("[TB] FAIL directed_result: result=%h inf=%b zero=%b, required result=%h inf=%b zero=%b",
                           dut_if.result, dut_if.inf, dut_if.zero, got.res, got.inf, got.zero);
               end
            end
         end
         if (c < 9) begin
            dut_if.in    = codes[c];
            dut_if.start = 1'b1;
            e.res  = exps[c];
            e.inf  = infs[c];
            e.zero = zeros[c];
            e.cyc  = cyc;
            sb.push_back(e);
         end else begin
            dut_if.start = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL directed_drain: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_stream();
      logic [7:0] tail [4];
      sb_t        e;
      sb_t        got;
      logic       exp_done;
      tail = '{8'h40, 8'hC0, 8'h7F, 8'h01};
      for (int c = 0; c < 262 + 6; c++) begin
         @(negedge aclk);
         exp_done = (sb.size() != 0) && (cyc - sb[0].cyc >= 3);
         checks++;
         if (dut_if.done !== exp_done) begin
            errors++;
            $display("[TB] FAIL stream_done: done=%b at cycle %0d, required %b", dut_if.done, cyc, exp_done);
         end
         if (exp_done) begin
            got = sb.pop_front();
            if (dut_if.done === 1'b1) begin
               checks++;
               if (dut_if.result !== got.res || dut_if.inf !== got.inf || dut_if.zero !== got.zero) begin
                  errors++;
                  $display("[TB] FAIL stream_result: result=%h inf=%b zero=%b, required result=%h inf=%b zero=%b",
                           dut_if.result, dut_if.inf, dut_if.zero, got.res, got.inf, got.zero);
               end
            end
         end
         if (c < 256 || (c >= 258 && c < 262)) begin
            dut_if.in    = (c < 256) ? 8'(c) : tail[c - 258];
            dut_if.start = 1'b1;
            e     = ref_model(dut_if.in);
            e.cyc = cyc;
            sb.push_back(e);
         end else begin
            dut_if.start = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL stream_drain: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset_midflight();
      sb_t  e;
      sb_t  got;
      logic exp_done;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         dut_if.in    = 8'h40 + 8'(i);
         dut_if.start = 1'b1;
      end
      @(negedge aclk);
      dut_if.start = 1'b0;
      checks++;
      if (dut_if.done !== 1'b1 || dut_if.result !== 32'h3F80_0000) begin
         errors++;
         $display("[TB] FAIL midflight_before: done=%b result=%h, required done=1 result=3f800000",
                  dut_if.done, dut_if.result);
      end
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if (dut_if.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midflight_done: done=%b, required 0", dut_if.done);
      end
      checks++;
      if (dut_if.result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midflight_result: result=%h, required 00000000", dut_if.result);
      end
      checks++;
      if (dut_if.inf !== 1'b0 || dut_if.zero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midflight_flags: inf=%b zero=%b, required inf=0 zero=0", dut_if.inf, dut_if.zero);
      end
      #1 aresetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         checks++;
         if (dut_if.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midflight_quiet: done=%b at cycle %0d, required 0", dut_if.done, cyc);
         end
      end
      for (int c = 0; c < 7; c++) begin
         @(negedge aclk);
         exp_done = (sb.size() != 0) && (cyc - sb[0].cyc >= 3);
         checks++;
         if (dut_if.done !== exp_done) begin
            errors++;
            $display("[TB] FAIL midflight_restart_done: done=%b at cycle %0d, required %b", dut_if.done, cyc, exp_done);
         end
         if (exp_done) begin
            got = sb.pop_front();
            if (dut_if.done === 1'b1) begin
               checks++;
               if (dut_if.result !== got.res || dut_if.inf !== got.inf || dut_if.zero !== got.zero) begin
                  errors++;
                  $display("[TB] FAIL midflight_restart_result: result=%h inf=%b zero=%b, required result=%h inf=%b zero=%b",
                           dut_if.result, dut_if.inf, dut_if.zero, got.res, got.inf, got.zero);
               end
            end
         end
         if (c == 0) begin
            dut_if.in    = 8'h41;
            dut_if.start = 1'b1;
            e.res  = 32'h3FC0_0000;
            e.inf  = 1'b0;
            e.zero = 1'b0;
            e.cyc  = cyc;
            sb.push_back(e);
         end else begin
            dut_if.start = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL midflight_drain: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_directed();
      test_stream();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
